// File: rtl/wb_regfile.sv
// RV32I writeback stage and 31-entry integer register file with two bypassed read ports.
// Optional retired-instruction counter is enabled by defining WB_INSTRET_EN.
module wb_regfile #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            W_valid,
    input  logic [4:0]      W_op,
    input  logic [2:0]      W_f3,
    input  logic [4:0]      W_rd,
    input  logic [XLEN-1:0] W_alu_out,
    input  logic [XLEN-1:0] W_ld_word,
    input  logic [4:0]      rs1_index,
    input  logic [4:0]      rs2_index,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]     instret
`endif
);

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    logic            w_writes_op;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_val;
    logic [XLEN-1:0] w_regs [0:31];

    always_comb begin
        w_writes_op = 1'b0;
        case (W_op)
            OP_LOAD, OP_OPIMM, OP_OP, OP_LUI,
            OP_AUIPC, OP_JAL, OP_JALR: w_writes_op = 1'b1;
            default:                   w_writes_op = 1'b0;
        endcase
    end

    assign wb_en = W_valid & w_writes_op & (W_rd != 5'd0);
    assign wb_rd = W_rd;

    // Load data: W_ld_word is the aligned word, the low address bits pick the lane.
    always_comb begin
        w_byte = W_ld_word[7:0];
        case (W_alu_out[1:0])
            2'd0:    w_byte = W_ld_word[7:0];
            2'd1:    w_byte = W_ld_word[15:8];
            2'd2:    w_byte = W_ld_word[23:16];
            default: w_byte = W_ld_word[31:24];
        endcase
        w_half = W_alu_out[1] ? W_ld_word[31:16] : W_ld_word[15:0];
        case (W_f3)
            3'b000:  w_load_val = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100:  w_load_val = {{(XLEN-8){1'b0}}, w_byte};
            3'b001:  w_load_val = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_load_val = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_val = W_ld_word;
        endcase
    end

    assign wb_data = (W_op == OP_LOAD) ? w_load_val : W_alu_out;

    // x0 is a constant; x1..x31 are individual registers so they can reset asynchronously.
    assign w_regs[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            logic [XLEN-1:0] r_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_q <= RESET_VAL;
                end else if (wb_en && (W_rd == 5'(gi))) begin
                    r_q <= wb_data;
                end
            end
            assign w_regs[gi] = r_q;
        end
    endgenerate

    assign rs1_data = (rs1_index == 5'd0)                ? '0 :
                      (wb_en && (rs1_index == W_rd))     ? wb_data :
                                                           w_regs[rs1_index];
    assign rs2_data = (rs2_index == 5'd0)                ? '0 :
                      (wb_en && (rs2_index == W_rd))     ? wb_data :
                                                           w_regs[rs2_index];

`ifdef WB_INSTRET_EN
    logic [63:0] r_instret;

    // Every valid W-stage instruction retires, whether or not it writes a register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instret <= 64'd0;
        end else if (W_valid) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret = r_instret;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Randomised self-checking bench for wb_regfile against an array-based reference model.
// Counter checks are compiled in only when WB_INSTRET_EN is defined.
module tb_wb_regfile;

    localparam logic [31:0] RV = 32'hA5A5_0F0F;

    logic        clk;
    logic        rst;
    logic        W_valid;
    logic [4:0]  W_op;
    logic [2:0]  W_f3;
    logic [4:0]  W_rd;
    logic [31:0] W_alu_out;
    logic [31:0] W_ld_word;
    logic [4:0]  rs1_index;
    logic [4:0]  rs2_index;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] m_rf [32];
    logic [63:0] m_instret;

    wb_regfile #(.XLEN(32), .RESET_VAL(RV)) dut (
        .clk       (clk),
        .rst       (rst),
        .W_valid   (W_valid),
        .W_op      (W_op),
        .W_f3      (W_f3),
        .W_rd      (W_rd),
        .W_alu_out (W_alu_out),
        .W_ld_word (W_ld_word),
        .rs1_index (rs1_index),
        .rs2_index (rs2_index),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data)
`ifdef WB_INSTRET_EN
        ,
        .instret   (instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit m_is_writer(input logic [4:0] op);
        return op inside {5'b00000, 5'b00100, 5'b01100, 5'b01101,
                          5'b00101, 5'b11011, 5'b11001};
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
        int unsigned off;
        int unsigned b;
        int unsigned h;
        off = addr % 4;
        b   = (word >> (8 * off)) % 256;
        h   = (word >> (16 * ((addr / 2) % 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? 32'(b - 256) : 32'(b);
            3'd4:    return 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            3'd5:    return 32'(h);
            default: return word;
        endcase
    endfunction

    function automatic bit m_en();
        return W_valid && m_is_writer(W_op) && (W_rd != 0);
    endfunction

    function automatic logic [31:0] m_wbdata();
        return (W_op == 5'b00000) ? m_load(W_f3, W_alu_out, W_ld_word) : W_alu_out;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (m_en() && idx == W_rd) return m_wbdata();
        return m_rf[idx];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = (i == 0) ? 32'd0 : RV;
        m_instret = 64'd0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] ldw,
                         input logic [4:0] r1, input logic [4:0] r2);
        W_valid = v; W_op = op; W_f3 = f3; W_rd = rd;
        W_alu_out = alu; W_ld_word = ldw; rs1_index = r1; rs2_index = r2;
    endtask

    task automatic tick();
        bit          en;
        logic [31:0] d;
        bit          cnt;
        en  = m_en();
        d   = m_wbdata();
        cnt = W_valid;
        @(posedge clk);
        if (rst && en) m_rf[W_rd] = d;
        if (rst && cnt) m_instret = m_instret + 64'd1;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 5'b01100, 3'd0, 5'd9, 32'h0000_0055, 32'd0, 5'd10, 5'd0);
        m_reset();
        #1;
        checks++;
        if (rs1_data !== RV) begin
            errors++; $display("FAIL reset_hold_read rs1=%h exp=%h", rs1_data, RV);
        end
        repeat (3) @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 3'd0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd0);
        #1;
        checks++;
        if (rs1_data !== RV) begin
            errors++; $display("FAIL reset_write_inhibit x9=%h exp=%h", rs1_data, RV);
        end
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rs1_index = 5'(i);
            rs2_index = 5'(31 - i);
            #1;
            checks++;
            if (rs1_data !== ((i == 0) ? 32'd0 : RV) || rs2_data !== ((i == 31) ? 32'd0 : RV)) begin
                errors++;
                $display("FAIL reset_read idx=%0d rs1=%h rs2=%h", i, rs1_data, rs2_data);
            end
        end
`ifdef WB_INSTRET_EN
        checks++;
        if (instret !== 64'd0) begin
            errors++; $display("FAIL reset_instret got=%0d exp=0", instret);
        end
`endif
        $display("reset: x0=0 x1..x31=%h", RV);
        @(posedge clk); #1;
    endtask

    task automatic test_alu_bypass();
        drive(1'b1, 5'b01100, 3'd0, 5'd5, 32'h1234_5678, 32'd0, 5'd5, 5'd5);
        @(negedge clk);
        checks++;
        if (wb_en !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h1234_5678 ||
            rs1_data !== 32'h1234_5678 || rs2_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL alu_bypass en=%b rd=%0d data=%h rs1=%h rs2=%h exp=12345678",
                     wb_en, wb_rd, wb_data, rs1_data, rs2_data);
        end
        tick();
        drive(1'b0, 5'b01100, 3'd0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd0);
        @(negedge clk);
        checks++;
        if (rs1_data !== 32'h1234_5678) begin
            errors++; $display("FAIL alu_stored x5=%h exp=12345678", rs1_data);
        end
        tick();
        drive(1'b1, 5'b01100, 3'd0, 5'd0, 32'hCAFE_0000, 32'd0, 5'd0, 5'd5);
        @(negedge clk);
        checks++;
        if (wb_en !== 1'b0 || rs1_data !== 32'd0 || rs2_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rd0_write en=%b x0=%h x5=%h", wb_en, rs1_data, rs2_data);
        end
        tick();
        $display("alu_bypass: x5=12345678, rd=0 ignored");
    endtask

    task automatic test_loads();
        logic [2:0]  f3_t  [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [1:0]  off_t [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd0};
        logic [31:0] exp_t [6] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080,
                                   32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 5'b00000, f3_t[i], 5'd10, {30'h0400_0000, off_t[i]},
                  32'h80FF_7F01, 5'd10, 5'd0);
            @(negedge clk);
            checks++;
            if (wb_en !== 1'b1 || wb_data !== exp_t[i] || rs1_data !== exp_t[i]) begin
                errors++;
                $display("FAIL load f3=%b off=%0d en=%b data=%h rs1=%h exp=%h",
                         f3_t[i], off_t[i], wb_en, wb_data, rs1_data, exp_t[i]);
            end
            $display("load f3=%b off=%0d -> %h", f3_t[i], off_t[i], wb_data);
            tick();
        end
    endtask

    task automatic test_nonwriting();
        logic [4:0] ops [3] = '{5'b01000, 5'b11000, 5'b01100};
        logic       vld [3] = '{1'b1, 1'b1, 1'b0};
        drive(1'b1, 5'b00100, 3'd0, 5'd7, 32'h0000_0777, 32'd0, 5'd0, 5'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(vld[i], ops[i], 3'd0, 5'd7, 32'hBAD0_0000 + 32'(i), 32'd0, 5'd7, 5'd7);
            @(negedge clk);
            checks++;
            if (wb_en !== 1'b0 || rs1_data !== 32'h0000_0777) begin
                errors++;
                $display("FAIL nonwrite op=%b valid=%b en=%b x7=%h exp=00000777",
                         ops[i], vld[i], wb_en, rs1_data);
            end
            tick();
        end
        drive(1'b0, 5'd0, 3'd0, 5'd0, 32'd0, 32'd0, 5'd7, 5'd0);
        #1;
        checks++;
        if (rs1_data !== 32'h0000_0777) begin
            errors++; $display("FAIL nonwrite_after x7=%h exp=00000777", rs1_data);
        end
        $display("nonwriting: x7 kept 00000777");
    endtask

    task automatic test_async_reset();
        drive(1'b1, 5'b01101, 3'd0, 5'd3, 32'hDEAD_BEEF, 32'd0, 5'd3, 5'd0);
        tick();
        drive(1'b1, 5'b01100, 3'd0, 5'd4, 32'h0000_1111, 32'd0, 5'd3, 5'd0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (rs1_data !== RV) begin
            errors++; $display("FAIL async_reset x3=%h exp=%h", rs1_data, RV);
        end
        @(posedge clk);
        m_reset();
        #1;
        rst = 1'b1;
        drive(1'b0, 5'd0, 3'd0, 5'd0, 32'd0, 32'd0, 5'd4, 5'd3);
        #1;
        checks++;
        if (rs1_data !== RV || rs2_data !== RV) begin
            errors++; $display("FAIL reset_drops_write x4=%h x3=%h exp=%h", rs1_data, rs2_data, RV);
        end
`ifdef WB_INSTRET_EN
        checks++;
        if (instret !== 64'd0) begin
            errors++; $display("FAIL async_reset_instret got=%0d exp=0", instret);
        end
`endif
        $display("async_reset: x3,x4 = %h", RV);
    endtask

    task automatic test_random();
        logic [4:0] ops [11] = '{5'b00000, 5'b00100, 5'b01100, 5'b01101, 5'b00101,
                                 5'b11011, 5'b11001, 5'b01000, 5'b11000, 5'b00011, 5'b11100};
        int bad;
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 3) != 0),
                  ops[$urandom_range(0, 10)],
                  3'($urandom_range(0, 7)),
                  5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31)),
                  $urandom, $urandom,
                  5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31)),
                  5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31)));
            @(negedge clk);
            bad = 0;
            checks++;
            if (wb_en !== m_en() || wb_rd !== W_rd) bad = 1;
            if (m_en() && wb_data !== m_wbdata()) bad = 1;
            if (rs1_data !== m_read(rs1_index) || rs2_data !== m_read(rs2_index)) bad = 1;
            if (bad) begin
                errors++;
                $display("FAIL random n=%0d en=%b/%b data=%h/%h rs1[%0d]=%h/%h rs2[%0d]=%h/%h",
                         n, wb_en, m_en(), wb_data, m_wbdata(), rs1_index, rs1_data,
                         m_read(rs1_index), rs2_index, rs2_data, m_read(rs2_index));
            end
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 3'd0, 5'd0, 32'd0, 32'd0, 5'(i), 5'(i));
            #1;
            checks++;
            if (rs1_data !== m_rf[i] || rs2_data !== m_rf[i]) begin
                errors++;
                $display("FAIL random_final x%0d rs1=%h rs2=%h exp=%h", i, rs1_data, rs2_data, m_rf[i]);
            end
        end
        $display("random: 300 cycles compared");
    endtask

`ifdef WB_INSTRET_EN
    task automatic test_instret();
        logic       vld [10] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1};
        logic [4:0] op  [10] = '{5'b01100, 5'b01000, 5'b01100, 5'b11000, 5'b00100,
                                 5'b00000, 5'b01100, 5'b11011, 5'b01100, 5'b00100};
        logic [4:0] rd  [10] = '{5'd1, 5'd7, 5'd2, 5'd0, 5'd0, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8};
        logic [63:0] base;
        checks++;
        if (instret !== m_instret) begin
            errors++; $display("FAIL instret_pre got=%0d exp=%0d", instret, m_instret);
        end
        base = m_instret;
        for (int i = 0; i < 10; i++) begin
            drive(vld[i], op[i], 3'd2, rd[i], $urandom, $urandom, 5'd0, 5'd0);
            tick();
        end
        checks++;
        if (instret !== base + 64'd7) begin
            errors++; $display("FAIL instret_count got=%0d exp=%0d", instret, base + 64'd7);
        end
        drive(1'b0, 5'd0, 3'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_instret;
        drive(1'b1, 5'b01000, 3'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        @(posedge clk); #1;
        checks++;
        if (instret !== 64'd0) begin
            errors++; $display("FAIL instret_wrap got=%h exp=0", instret);
        end
        $display("instret: +7 over 10 cycles, wrap to 0");
    endtask
`endif

    initial begin
        rst = 1'b0;
        drive(1'b0, 5'd0, 3'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        m_reset();
        @(posedge clk); #1;
        test_reset();
        test_alu_bypass();
        test_loads();
        test_nonwriting();
        test_async_reset();
        test_random();
`ifdef WB_INSTRET_EN
        test_instret();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
